// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// One radix-2 step per busy cycle: shift-add for MULT/MULTU, restoring
// division for DIV/DIVU. Signed operations run on magnitudes and the
// signs are applied on the completion edge.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [5:0]       r_cnt;
  logic             r_is_div;
  logic             r_neg_q;   // product / quotient must be negated
  logic             r_neg_r;   // remainder takes the dividend's sign
  logic             r_div0;    // divisor was zero
  logic [WIDTH-1:0] r_rs;      // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] r_b;       // multiplier / divisor magnitude
  logic [W2-1:0]    r_acc;     // product accumulator or remainder:quotient

  logic             w_signed;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [W2-1:0]    w_mul_next;
  logic [WIDTH:0]   w_div_diff;
  logic [W2-1:0]    w_div_next;
  logic [W2-1:0]    w_acc_next;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Operand magnitudes at launch; op[0]=0 selects the signed variants
  always_comb begin
    w_signed = ~op[0];
    w_rs_mag = (w_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    w_rt_mag = (w_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
  end

  // One iteration of the active algorithm plus the completion fix-up
  always_comb begin
    // Shift-add: add multiplicand to the upper half when the LSB is set,
    // then shift the whole accumulator right (carry enters at the top).
    w_mul_sum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    // Restoring division: trial-subtract from the left-shifted remainder,
    // keep the difference and shift in a 1 when it does not borrow.
    w_div_diff = r_acc[W2-1:WIDTH-1] - {1'b0, r_b};
    if (w_div_diff[WIDTH])
      w_div_next = {r_acc[W2-2:0], 1'b0};
    else
      w_div_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    w_acc_next = r_is_div ? w_div_next : w_mul_next;

    w_prod = r_neg_q ? -w_acc_next : w_acc_next;
    w_quot = r_neg_q ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
    w_rem  = r_neg_r ? -w_acc_next[W2-1:WIDTH] : w_acc_next[W2-1:WIDTH];

    if (!r_is_div) begin
      w_res_hi = w_prod[W2-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end else if (r_div0) begin
      w_res_hi = r_rs;
      w_res_lo = '1;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quot;
    end
  end

  // Control, datapath and HI/LO update; start has priority over mthi/mtlo
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_rs     <= '0;
      r_b      <= '0;
      r_acc    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt - 6'd1;
        if (r_cnt == 6'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
        end
      end else if (start) begin
        r_busy   <= 1'b1;
        r_cnt    <= 6'd32;
        r_is_div <= op[1];
        r_neg_q  <= w_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
        r_neg_r  <= w_signed & rs_data[WIDTH-1];
        r_div0   <= (rt_data == '0);
        r_rs     <= rs_data;
        r_b      <= w_rt_mag;
        r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
      end else begin
        if (mthi) r_hi <= wr_data;
        if (mtlo) r_lo <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected HI:LO values are queued
// at launch and popped when the done pulse appears.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic for randomised operands
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    int sa, sb;
    logic [31:0] q, r;
    case (o)
      2'b00: begin
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {r, q};
      end
    endcase
  endfunction

  // Drive one start cycle (called at posedge+1 while idle) and queue the expectation
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count busy cycles until done, bounded to 40 cycles
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [1:0]  t_op [3];
    logic [31:0] t_a [3];
    logic [31:0] t_b [3];
    logic [63:0] t_e [3];
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] e, got;
    int nb; bit seen;
    t_op = '{2'b01, 2'b00, 2'b01};
    t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    t_b  = '{32'hFFFF_FFFF, 32'h5, 32'h5};
    t_e  = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0004_FFFF_FFF1};
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        o = t_op[i]; a = t_a[i]; b = t_b[i]; e = t_e[i];
      end else begin
        o = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom; e = model(o, a, b);
      end
      launch(o, a, b, e);
      wait_done(nb, seen);
      checks++; if (!seen) begin failures++; $display("FAIL mul%0d_timeout got=no_done exp=done", i); end
      checks++; if (nb != 32) begin failures++; $display("FAIL mul%0d_busy_cycles got=%0d exp=32", i, nb); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {hi, lo};
        checks++; if (got !== e) begin failures++; $display("FAIL mul%0d op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, got, e); end
        $display("mul%0d op=%0d a=%h b=%h hi:lo=%h", i, o, a, b, got);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0]  t_op [5];
    logic [31:0] t_a [5];
    logic [31:0] t_b [5];
    logic [63:0] t_e [5];
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] e, got;
    int nb; bit seen;
    t_op = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    t_a  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
    t_b  = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
    t_e  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E, 64'h0000_0000_8000_0000,
             64'h0000_0007_FFFF_FFFF, 64'hFFFF_FFF9_FFFF_FFFF};
    for (int i = 0; i < 11; i++) begin
      if (i < 5) begin
        o = t_op[i]; a = t_a[i]; b = t_b[i]; e = t_e[i];
      end else begin
        o = 2'($urandom_range(2, 3)); a = $urandom; b = $urandom >> $urandom_range(0, 28);
        if (b == 32'd0) b = 32'd3;
        e = model(o, a, b);
      end
      launch(o, a, b, e);
      wait_done(nb, seen);
      checks++; if (!seen) begin failures++; $display("FAIL div%0d_timeout got=no_done exp=done", i); end
      checks++; if (nb != 32) begin failures++; $display("FAIL div%0d_busy_cycles got=%0d exp=32", i, nb); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {hi, lo};
        checks++; if (got !== e) begin failures++; $display("FAIL div%0d op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, got, e); end
        $display("div%0d op=%0d a=%h b=%h hi:lo=%h", i, o, a, b, got);
      end
    end
  endtask

  // Start accepted in the done cycle; done must drop immediately after
  task automatic test_back_to_back();
    logic [63:0] e;
    int nb; bit seen;
    launch(2'b01, 32'd11, 32'd13, 64'd143);
    wait_done(nb, seen);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL b2b_first got=%h exp=%h", {hi, lo}, e); end
    end
    launch(2'b11, 32'd1000, 32'd9, {32'd1, 32'd111});
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_one_cycle got=%b exp=0", done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accepted got=%b exp=1", busy); end
    wait_done(nb, seen);
    checks++; if (!seen || nb != 32) begin failures++; $display("FAIL b2b_second_latency got=%0d seen=%0d exp=32", nb, seen); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL b2b_second got=%h exp=%h", {hi, lo}, e); end
    end
    $display("b2b hi:lo=%h", {hi, lo});
    @(posedge clk); #1;
  endtask

  // Start and mthi during busy are ignored; hi/lo hold until completion; mt* while idle
  task automatic test_ignore_and_mt();
    logic [31:0] old_hi, old_lo;
    logic [63:0] e;
    int nb; bit seen;
    old_hi = hi; old_lo = lo;
    launch(2'b01, 32'd2, 32'd3, 64'd6);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'b01; rs_data = 32'd9; rt_data = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    mthi = 1'b1; wr_data = 32'h0000_DEAD;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++; if ({hi, lo} !== {old_hi, old_lo}) begin failures++; $display("FAIL hold_during_busy got=%h exp=%h", {hi, lo}, {old_hi, old_lo}); end
    wait_done(nb, seen);
    checks++; if (!seen || nb != 22) begin failures++; $display("FAIL ignore_latency got=%0d seen=%0d exp=22", nb, seen); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL ignore_result got=%h exp=%h", {hi, lo}, e); end
    end
    $display("ignore hi:lo=%h", {hi, lo});
    @(posedge clk); #1;
    mtlo = 1'b1; wr_data = 32'h0000_1234;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++; if ({hi, lo} !== 64'h0000_0000_0000_1234) begin failures++; $display("FAIL mtlo got=%h exp=0000000000001234", {hi, lo}); end
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++; if ({hi, lo} !== 64'hCAFE_F00D_CAFE_F00D) begin failures++; $display("FAIL mthi_mtlo got=%h exp=cafef00dcafef00d", {hi, lo}); end
    mtlo = 1'b1; wr_data = 32'h5555_5555;
    launch(2'b01, 32'd1, 32'd1, 64'd1);
    mtlo = 1'b0;
    checks++; if (lo !== 32'hCAFE_F00D) begin failures++; $display("FAIL start_wins_mtlo got=%h exp=cafef00d", lo); end
    wait_done(nb, seen);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL start_wins_result got=%h exp=%h", {hi, lo}, e); end
    end
    $display("mt hi:lo=%h", {hi, lo});
    @(posedge clk); #1;
  endtask

  // Reset mid-operation aborts with no result and no done pulse
  task automatic test_abort();
    int dcount;
    start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL abort_hilo got=%h exp=0", {hi, lo}); end
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    checks++; if (dcount != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dcount); end
    $display("abort busy=%b hi:lo=%h", busy, {hi, lo});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_ignore_and_mt();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
